// File: rtl/color_slot_store_pkg.sv
// +------------------------------------------------------------------+
// | color_store_pkg : shared op/status codes and FSM states           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package color_store_pkg;

  typedef enum logic [1:0] {
    OP_STORE  = 2'b00,
    OP_FETCH  = 2'b01,
    OP_LOOKUP = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_OK    = 3'b000,
    ST_DUP   = 3'b001,
    ST_FULL  = 3'b010,
    ST_MISS  = 3'b011,
    ST_ERR   = 3'b100,
    ST_EVICT = 3'b101
  } status_e;

  localparam int COLOR_EMPTY = 0;
  localparam int RED         = 1;
  localparam int GREEN       = 2;
  localparam int BLUE        = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SCAN   = 2'b01,
    S_COMMIT = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/color_slot_store_if.sv
// +------------------------------------------------------------------+
// | color_slot_store_if : command/response handshake bundle           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface color_slot_store_if #(
  parameter int COLOR_W = 2,
  parameter int SLOT_W  = 2
) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [COLOR_W-1:0] cmd_color;
  logic               rsp_valid;
  logic [2:0]         rsp_status;
  logic [SLOT_W-1:0]  rsp_slot;

  modport master (
    output cmd_valid, cmd_op, cmd_color,
    input  cmd_ready, rsp_valid, rsp_status, rsp_slot
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_color,
    output cmd_ready, rsp_valid, rsp_status, rsp_slot
  );

endinterface

`default_nettype wire

// File: rtl/color_slot_store.sv
// +------------------------------------------------------------------+
// | color_slot_store : deduplicating colour-slot store, serial scan   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module color_slot_store
  import color_store_pkg::*;
#(
  parameter  int NUM_SLOTS = 3,
  parameter  int COLOR_W   = 2,
  parameter  int EVICT_EN  = 0,
  localparam int SLOT_W    = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1,
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  color_slot_store_if.slave                 bus,
  output logic [NUM_SLOTS*COLOR_W-1:0]      slots_flat,
  output logic [CNT_W-1:0]                  occupancy,
  output logic                              full,
  output logic                              empty
);

  localparam logic [SLOT_W-1:0] C_LAST = SLOT_W'(NUM_SLOTS - 1);

  state_e             r_state;
  logic [COLOR_W-1:0] r_slots [NUM_SLOTS];
  op_e                r_op;
  logic [COLOR_W-1:0] r_color;
  logic [SLOT_W-1:0]  r_idx, r_match_idx, r_empty_idx, r_ptr;
  logic               r_match_hit, r_empty_hit;
  logic               r_wr_en, r_clr_en, r_ptr_inc;
  logic [COLOR_W-1:0] r_wr_val;
  logic [CNT_W-1:0]   r_occ_next;

  logic [COLOR_W-1:0] w_cur;
  logic               w_match, w_empt;
  logic [SLOT_W-1:0]  w_midx, w_eidx;
  status_e            w_status;
  logic [SLOT_W-1:0]  w_slot;
  logic               w_wr, w_inc;
  logic [COLOR_W-1:0] w_val;
  logic [CNT_W-1:0]   w_occ;

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (r_idx == SLOT_W'(i)) w_cur = r_slots[i];
  end

  // Fold the slot under the scan index into the captured results so the
  // final decision can be made on the last scan cycle.
  assign w_match = r_match_hit | (w_cur == r_color);
  assign w_midx  = r_match_hit ? r_match_idx : r_idx;
  assign w_empt  = r_empty_hit | (w_cur == '0);
  assign w_eidx  = r_empty_hit ? r_empty_idx : r_idx;

  always_comb begin
    w_status = ST_MISS;
    w_slot   = '0;
    w_wr     = 1'b0;
    w_inc    = 1'b0;
    w_val    = r_color;
    w_occ    = occupancy;
    case (r_op)
      OP_STORE: begin
        if (w_match) begin
          w_status = ST_DUP;
          w_slot   = w_midx;
        end else if (w_empt) begin
          w_status = ST_OK;
          w_slot   = w_eidx;
          w_wr     = 1'b1;
          w_occ    = occupancy + CNT_W'(1);
        end else if (EVICT_EN != 0) begin
          w_status = ST_EVICT;
          w_slot   = r_ptr;
          w_wr     = 1'b1;
          w_inc    = 1'b1;
        end else begin
          w_status = ST_FULL;
        end
      end
      OP_FETCH: begin
        if (w_match) begin
          w_status = ST_OK;
          w_slot   = w_midx;
          w_wr     = 1'b1;
          w_val    = '0;
          w_occ    = occupancy - CNT_W'(1);
        end
      end
      OP_LOOKUP: begin
        if (w_match) begin
          w_status = ST_OK;
          w_slot   = w_midx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
      r_op           <= OP_STORE;
      r_color        <= '0;
      r_idx          <= '0;
      r_match_idx    <= '0;
      r_empty_idx    <= '0;
      r_ptr          <= '0;
      r_match_hit    <= 1'b0;
      r_empty_hit    <= 1'b0;
      r_wr_en        <= 1'b0;
      r_clr_en       <= 1'b0;
      r_ptr_inc      <= 1'b0;
      r_wr_val       <= '0;
      r_occ_next     <= '0;
      occupancy      <= '0;
      full           <= 1'b0;
      empty          <= 1'b1;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_status <= 3'b000;
      bus.rsp_slot   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            r_op          <= op_e'(bus.cmd_op);
            r_color       <= bus.cmd_color;
            bus.cmd_ready <= 1'b0;
            r_wr_en       <= 1'b0;
            r_ptr_inc     <= 1'b0;
            r_clr_en      <= (op_e'(bus.cmd_op) == OP_CLEAR);
            r_idx         <= '0;
            r_match_hit   <= 1'b0;
            r_empty_hit   <= 1'b0;
            if (op_e'(bus.cmd_op) == OP_CLEAR) begin
              r_state        <= S_COMMIT;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_status <= ST_OK;
              bus.rsp_slot   <= '0;
            end else if (bus.cmd_color == '0) begin
              r_state        <= S_COMMIT;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_status <= ST_ERR;
              bus.rsp_slot   <= '0;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (r_idx == C_LAST) begin
            r_state        <= S_COMMIT;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_status <= w_status;
            bus.rsp_slot   <= w_slot;
            r_wr_en        <= w_wr;
            r_wr_val       <= w_val;
            r_ptr_inc      <= w_inc;
            r_occ_next     <= w_occ;
          end else begin
            r_idx       <= r_idx + SLOT_W'(1);
            r_match_hit <= w_match;
            r_match_idx <= w_midx;
            r_empty_hit <= w_empt;
            r_empty_idx <= w_eidx;
          end
        end
        S_COMMIT: begin
          r_state       <= S_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          if (r_clr_en) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= '0;
            r_ptr     <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
          end else if (r_wr_en) begin
            for (int i = 0; i < NUM_SLOTS; i++)
              if (bus.rsp_slot == SLOT_W'(i)) r_slots[i] <= r_wr_val;
            occupancy <= r_occ_next;
            full      <= (r_occ_next == CNT_W'(NUM_SLOTS));
            empty     <= (r_occ_next == '0);
          end
          if (r_ptr_inc)
            r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + SLOT_W'(1);
          r_wr_en   <= 1'b0;
          r_clr_en  <= 1'b0;
          r_ptr_inc <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_flat
    assign slots_flat[gi*COLOR_W +: COLOR_W] = r_slots[gi];
  end

endmodule

`default_nettype wire
